register_block_arbiter: RTL and testbench

Cycle-by-cycle arbiter that shares one `register_block` (16 lanes × 64 regs × 32 b, 2 read ports, 1 write port, single `warp_selector`) between the issue stage's operand read request and two writeback sources (WB0 = ALU, WB1 = LSU). It drives the register block's enables, addresses and `warp_selector` directly, plus the wdata-mux select. The block resolves three things: the one-warp-per-cycle restriction, write-port contention, and same-address read/write hazards.

---
 rtl/register_block_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_register_block_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_block_arbiter.sv
// register_block_arbiter
// ----------------------
// Shares one register_block (2 read ports, 1 write port, one warp_selector)
// between the operand-read request from issue and two writeback sources
// (WB0 = ALU, WB1 = LSU). Grants are combinational from current inputs and
// state. The only state is the writeback round-robin pointer, the read
// starvation counter and the last granted warp.
//
// Optional feature macro: REGFILE_ARB_BYPASS_EN
//   defined   : a read/write address hazard does not block the co-grant.
//               bypass_k flags the operand that must take the written data.
//   undefined : a hazard blocks the co-grant. bypass_0/1 are tied to 0.
module register_block_arbiter #(
    parameter int NUM_LANES    = 16,
    parameter int ADDR_W       = 6,
    parameter int WARP_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // operand read request
    input  logic                 rd_valid,
    input  logic [WARP_W-1:0]    rd_warp,
    input  logic [ADDR_W-1:0]    rd_addr_0,
    input  logic [ADDR_W-1:0]    rd_addr_1,
    input  logic [NUM_LANES-1:0] rd_mask_0,
    input  logic [NUM_LANES-1:0] rd_mask_1,
    output logic                 rd_ready,
    // writeback requests
    input  logic                 wb_valid_0,
    input  logic                 wb_valid_1,
    input  logic [WARP_W-1:0]    wb_warp_0,
    input  logic [WARP_W-1:0]    wb_warp_1,
    input  logic [ADDR_W-1:0]    wb_addr_0,
    input  logic [ADDR_W-1:0]    wb_addr_1,
    input  logic [NUM_LANES-1:0] wb_mask_0,
    input  logic [NUM_LANES-1:0] wb_mask_1,
    output logic                 wb_ready_0,
    output logic                 wb_ready_1,
    // register_block controls
    output logic [NUM_LANES-1:0] write_en,
    output logic [ADDR_W-1:0]    waddr,
    output logic                 wb_sel,
    output logic [NUM_LANES-1:0] read_en_0,
    output logic [NUM_LANES-1:0] read_en_1,
    output logic [ADDR_W-1:0]    raddr_0,
    output logic [ADDR_W-1:0]    raddr_1,
    output logic [WARP_W-1:0]    warp_selector,
    output logic                 bypass_0,
    output logic                 bypass_1
);

    // The starvation counter is 4 bits wide because STARVE_LIMIT is at most 15.
    localparam int          CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic                 rr_ptr_reg;
    logic [CNT_W-1:0]     starve_cnt_reg;
    logic [WARP_W-1:0]    last_warp_reg;

    // ---------------------------------------------------------------------
    // Write candidate W
    // ---------------------------------------------------------------------
    logic                 w_valid;
    logic                 w_id;
    logic [WARP_W-1:0]    w_warp;
    logic [ADDR_W-1:0]    w_addr;
    logic [NUM_LANES-1:0] w_mask;

    // Pick the writeback candidate: the lone valid source, or rr_ptr when both are valid.
    always_comb begin
        w_valid = wb_valid_0 | wb_valid_1;
        if (wb_valid_0 && wb_valid_1) begin
            w_id = rr_ptr_reg;
        end else begin
            w_id = wb_valid_1;
        end
        w_warp = w_id ? wb_warp_1 : wb_warp_0;
        w_addr = w_id ? wb_addr_1 : wb_addr_0;
        w_mask = w_id ? wb_mask_1 : wb_mask_0;
    end

    // ---------------------------------------------------------------------
    // Per-read-port view: hazard detection and output steering
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0]    rd_addr_arr [2];
    logic [NUM_LANES-1:0] rd_mask_arr [2];
    logic [NUM_LANES-1:0] read_en_arr [2];
    logic [ADDR_W-1:0]    raddr_arr   [2];
    logic [1:0]           hazard;
    logic [1:0]           bypass_vec;

    logic                 rd_grant;
    logic                 wr_grant;

    assign rd_addr_arr[0] = rd_addr_0;
    assign rd_addr_arr[1] = rd_addr_1;
    assign rd_mask_arr[0] = rd_mask_0;
    assign rd_mask_arr[1] = rd_mask_1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            // A hazard needs the same warp, same register and at least one shared lane.
            assign hazard[gi] = rd_valid && w_valid
                                && (rd_warp == w_warp)
                                && (rd_addr_arr[gi] == w_addr)
                                && (|(rd_mask_arr[gi] & w_mask));

            // An ungranted read port drives zero enables and a zero address.
            assign read_en_arr[gi] = rd_grant ? rd_mask_arr[gi] : '0;
            assign raddr_arr[gi]   = rd_grant ? rd_addr_arr[gi] : '0;

`ifdef REGFILE_ARB_BYPASS_EN
            // The operand collector substitutes written lanes when both sides ran on a hazard.
            assign bypass_vec[gi] = rd_grant && wr_grant && hazard[gi];
`else
            assign bypass_vec[gi] = 1'b0;
`endif
        end
    endgenerate

    assign read_en_0 = read_en_arr[0];
    assign read_en_1 = read_en_arr[1];
    assign raddr_0   = raddr_arr[0];
    assign raddr_1   = raddr_arr[1];
    assign bypass_0  = bypass_vec[0];
    assign bypass_1  = bypass_vec[1];

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic blocked;
    logic same_warp;
    logic starve_mode;

`ifdef REGFILE_ARB_BYPASS_EN
    assign blocked = 1'b0;
`else
    assign blocked = |hazard;
`endif

    assign same_warp   = (rd_warp == w_warp);
    assign starve_mode = rd_valid && (starve_cnt_reg == STARVE_MAX);

    // Decide the grants. Writes win in normal mode, reads win once starved.
    // Holding rst_n low forces every grant, and so every output, to zero.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (rst_n) begin
            if (!w_valid) begin
                rd_grant = rd_valid;
            end else if (starve_mode) begin
                rd_grant = 1'b1;
                wr_grant = same_warp && !blocked;
            end else begin
                wr_grant = 1'b1;
                rd_grant = rd_valid && same_warp && !blocked;
            end
        end
    end

    // Drive the handshake, write-port and warp_selector outputs from the grants.
    always_comb begin
        rd_ready   = rd_grant;
        wb_ready_0 = wr_grant && !w_id;
        wb_ready_1 = wr_grant && w_id;
        write_en   = wr_grant ? w_mask : '0;
        waddr      = wr_grant ? w_addr : '0;
        wb_sel     = wr_grant && w_id;
        if (rd_grant) begin
            warp_selector = rd_warp;
        end else if (wr_grant) begin
            warp_selector = w_warp;
        end else begin
            warp_selector = last_warp_reg;
        end
    end

    // ---------------------------------------------------------------------
    // State update
    // ---------------------------------------------------------------------

    // Round-robin pointer points away from the source that was just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 1'b0;
        end else if (wr_grant) begin
            rr_ptr_reg <= !w_id;
        end
    end

    // Count consecutive stalled read cycles, saturating at STARVE_LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (rd_valid && !rd_grant) begin
            if (starve_cnt_reg != STARVE_MAX) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end else begin
            starve_cnt_reg <= '0;
        end
    end

    // Remember the last granted warp so warp_selector is stable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_warp_reg <= '0;
        end else if (rd_grant || wr_grant) begin
            last_warp_reg <= warp_selector;
        end
    end

endmodule

// File: tb/tb_register_block_arbiter.sv
// Directed bench for register_block_arbiter: single-cycle vectors applied
// from reset state, then multi-cycle sequences for round robin, hazard
// retry, starvation, idle hold and mid-operation reset.
module tb_register_block_arbiter;

`ifdef REGFILE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rd_valid;
    logic [3:0]  rd_warp;
    logic [5:0]  rd_addr_0, rd_addr_1;
    logic [15:0] rd_mask_0, rd_mask_1;
    logic        rd_ready;
    logic        wb_valid_0, wb_valid_1;
    logic [3:0]  wb_warp_0, wb_warp_1;
    logic [5:0]  wb_addr_0, wb_addr_1;
    logic [15:0] wb_mask_0, wb_mask_1;
    logic        wb_ready_0, wb_ready_1;
    logic [15:0] write_en;
    logic [5:0]  waddr;
    logic        wb_sel;
    logic [15:0] read_en_0, read_en_1;
    logic [5:0]  raddr_0, raddr_1;
    logic [3:0]  warp_selector;
    logic        bypass_0, bypass_1;

    int total = 0;
    int bad   = 0;

    register_block_arbiter #(
        .NUM_LANES(16), .ADDR_W(6), .WARP_W(4), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rd_warp(rd_warp),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_mask_0(rd_mask_0), .rd_mask_1(rd_mask_1),
        .rd_ready(rd_ready),
        .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
        .wb_warp_0(wb_warp_0), .wb_warp_1(wb_warp_1),
        .wb_addr_0(wb_addr_0), .wb_addr_1(wb_addr_1),
        .wb_mask_0(wb_mask_0), .wb_mask_1(wb_mask_1),
        .wb_ready_0(wb_ready_0), .wb_ready_1(wb_ready_1),
        .write_en(write_en), .waddr(waddr), .wb_sel(wb_sel),
        .read_en_0(read_en_0), .read_en_1(read_en_1),
        .raddr_0(raddr_0), .raddr_1(raddr_1),
        .warp_selector(warp_selector),
        .bypass_0(bypass_0), .bypass_1(bypass_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;  logic [3:0] rw;  logic [5:0] ra0; logic [5:0] ra1;
        logic [15:0] rm0; logic [15:0] rm1;
        logic        wv0; logic [3:0] ww0; logic [5:0] wa0; logic [15:0] wm0;
        logic        wv1; logic [3:0] ww1; logic [5:0] wa1; logic [15:0] wm1;
        logic        e_rdy; logic e_wr0; logic e_wr1;
        logic [15:0] e_wen; logic [5:0] e_waddr; logic e_sel;
        logic [15:0] e_ren0; logic [15:0] e_ren1; logic [5:0] e_ra0; logic [5:0] e_ra1;
        logic [3:0]  e_ws; logic e_byp0; logic e_byp1;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_valid = 0; rd_warp = 0; rd_addr_0 = 0; rd_addr_1 = 0; rd_mask_0 = 0; rd_mask_1 = 0;
        wb_valid_0 = 0; wb_warp_0 = 0; wb_addr_0 = 0; wb_mask_0 = 0;
        wb_valid_1 = 0; wb_warp_1 = 0; wb_addr_1 = 0; wb_mask_1 = 0;
    endtask

    // Called at a negedge; returns at a later negedge with rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_read(input logic v, input logic [3:0] w, input logic [5:0] a0, input logic [5:0] a1,
                            input logic [15:0] m0, input logic [15:0] m1);
        rd_valid = v; rd_warp = w; rd_addr_0 = a0; rd_addr_1 = a1; rd_mask_0 = m0; rd_mask_1 = m1;
    endtask

    task automatic set_wb0(input logic v, input logic [3:0] w, input logic [5:0] a, input logic [15:0] m);
        wb_valid_0 = v; wb_warp_0 = w; wb_addr_0 = a; wb_mask_0 = m;
    endtask

    task automatic set_wb1(input logic v, input logic [3:0] w, input logic [5:0] a, input logic [15:0] m);
        wb_valid_1 = v; wb_warp_1 = w; wb_addr_1 = a; wb_mask_1 = m;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_ready"},   rd_ready,      0);
        check({tag, ".wb_ready_0"}, wb_ready_0,    0);
        check({tag, ".wb_ready_1"}, wb_ready_1,    0);
        check({tag, ".write_en"},   write_en,      0);
        check({tag, ".waddr"},      waddr,         0);
        check({tag, ".wb_sel"},     wb_sel,        0);
        check({tag, ".read_en_0"},  read_en_0,     0);
        check({tag, ".read_en_1"},  read_en_1,     0);
        check({tag, ".raddr_0"},    raddr_0,       0);
        check({tag, ".raddr_1"},    raddr_1,       0);
        check({tag, ".warp_sel"},   warp_selector, 0);
        check({tag, ".bypass_0"},   bypass_0,      0);
        check({tag, ".bypass_1"},   bypass_1,      0);
    endtask

    initial begin
        // Each vector is applied from reset state (rr_ptr=0, starve_cnt=0, last_warp=0).
        //            rv rw ra0 ra1 rm0 rm1 | wv0 ww0 wa0 wm0 | wv1 ww1 wa1 wm1 | rdy wr0 wr1 wen waddr sel | ren0 ren1 ra0 ra1 | ws b0 b1
        vecs[0]  = '{0,0,0,0,16'h0,16'h0, 0,0,0,16'h0, 0,0,0,16'h0,
                     0,0,0,16'h0,0,0, 16'h0,16'h0,0,0, 0,0,0};
        vecs[1]  = '{1,5,1,2,16'h00FF,16'hFF00, 0,0,0,16'h0, 0,0,0,16'h0,
                     1,0,0,16'h0,0,0, 16'h00FF,16'hFF00,1,2, 5,0,0};
        vecs[2]  = '{0,0,0,0,16'h0,16'h0, 1,2,3,16'h000F, 0,0,0,16'h0,
                     0,1,0,16'h000F,3,0, 16'h0,16'h0,0,0, 2,0,0};
        vecs[3]  = '{0,0,0,0,16'h0,16'h0, 0,0,0,16'h0, 1,6,6'h3F,16'hFFFF,
                     0,0,1,16'hFFFF,6'h3F,1, 16'h0,16'h0,0,0, 6,0,0};
        vecs[4]  = '{0,0,0,0,16'h0,16'h0, 1,1,10,16'h0001, 1,2,11,16'h0002,
                     0,1,0,16'h0001,10,0, 16'h0,16'h0,0,0, 1,0,0};
        vecs[5]  = '{1,3,5,6,16'hFFFF,16'hFFFF, 1,3,5,16'hFFFF, 0,0,0,16'h0,
                     BYP,1,0,16'hFFFF,5,0, BYP ? 16'hFFFF : 16'h0, BYP ? 16'hFFFF : 16'h0,
                     BYP ? 6'd5 : 6'd0, BYP ? 6'd6 : 6'd0, 3,BYP,0};
        vecs[6]  = '{1,4,1,2,16'h1234,16'h8000, 0,0,0,16'h0, 1,4,8,16'h0F0F,
                     1,0,1,16'h0F0F,8,1, 16'h1234,16'h8000,1,2, 4,0,0};
        vecs[7]  = '{1,7,3,4,16'hFFFF,16'hFFFF, 1,1,3,16'hFFFF, 0,0,0,16'h0,
                     0,1,0,16'hFFFF,3,0, 16'h0,16'h0,0,0, 1,0,0};
        vecs[8]  = '{1,3,5,5,16'hFF00,16'hFF00, 1,3,5,16'h00FF, 0,0,0,16'h0,
                     1,1,0,16'h00FF,5,0, 16'hFF00,16'hFF00,5,5, 3,0,0};
        vecs[9]  = '{0,0,0,0,16'h0,16'h0, 1,2,4,16'h0000, 0,0,0,16'h0,
                     0,1,0,16'h0000,4,0, 16'h0,16'h0,0,0, 2,0,0};
        vecs[10] = '{1,0,2,9,16'h0001,16'h0001, 0,0,0,16'h0, 1,0,9,16'h0001,
                     BYP,0,1,16'h0001,9,1, BYP ? 16'h0001 : 16'h0, BYP ? 16'h0001 : 16'h0,
                     BYP ? 6'd2 : 6'd0, BYP ? 6'd9 : 6'd0, 0,0,BYP};
        vecs[11] = '{1,5,1,2,16'h0003,16'h0300, 1,5,7,16'h00F0, 1,6,8,16'hFFFF,
                     1,1,0,16'h00F0,7,0, 16'h0003,16'h0300,1,2, 5,0,0};

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);

        // ---------------- table-driven single-cycle vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            idle_inputs();
            do_reset();
            set_read(vecs[i].rv, vecs[i].rw, vecs[i].ra0, vecs[i].ra1, vecs[i].rm0, vecs[i].rm1);
            set_wb0(vecs[i].wv0, vecs[i].ww0, vecs[i].wa0, vecs[i].wm0);
            set_wb1(vecs[i].wv1, vecs[i].ww1, vecs[i].wa1, vecs[i].wm1);
            #1;
            check($sformatf("v%0d.rd_ready", i),   rd_ready,      vecs[i].e_rdy);
            check($sformatf("v%0d.wb_ready_0", i), wb_ready_0,    vecs[i].e_wr0);
            check($sformatf("v%0d.wb_ready_1", i), wb_ready_1,    vecs[i].e_wr1);
            check($sformatf("v%0d.write_en", i),   write_en,      vecs[i].e_wen);
            check($sformatf("v%0d.waddr", i),      waddr,         vecs[i].e_waddr);
            check($sformatf("v%0d.wb_sel", i),     wb_sel,        vecs[i].e_sel);
            check($sformatf("v%0d.read_en_0", i),  read_en_0,     vecs[i].e_ren0);
            check($sformatf("v%0d.read_en_1", i),  read_en_1,     vecs[i].e_ren1);
            check($sformatf("v%0d.raddr_0", i),    raddr_0,       vecs[i].e_ra0);
            check($sformatf("v%0d.raddr_1", i),    raddr_1,       vecs[i].e_ra1);
            check($sformatf("v%0d.warp_sel", i),   warp_selector, vecs[i].e_ws);
            check($sformatf("v%0d.bypass_0", i),   bypass_0,      vecs[i].e_byp0);
            check($sformatf("v%0d.bypass_1", i),   bypass_1,      vecs[i].e_byp1);
            $display("vector %0d applied: rd_ready=%0b wb_ready=%0b%0b ws=%0d", i, rd_ready, wb_ready_1, wb_ready_0, warp_selector);
            @(negedge clk);
        end

        // ---------------- reset with all requests valid ----------------
        idle_inputs();
        rst_n = 1'b0;
        set_read(1, 8, 6'h11, 6'h12, 16'hAAAA, 16'h5555);
        set_wb0(1, 3, 6'h21, 16'hFFFF);
        set_wb1(1, 3, 6'h22, 16'h00FF);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("in_reset");
        $display("reset held: all outputs sampled");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset.wb_ready_0", wb_ready_0, 1);
        check("post_reset.wb_ready_1", wb_ready_1, 0);
        check("post_reset.wb_sel",     wb_sel,     0);
        $display("first cycle after reset: wb_ready_0=%0b", wb_ready_0);
        @(negedge clk);

        // ---------------- round robin between WB0 and WB1 ----------------
        idle_inputs();
        do_reset();
        set_wb0(1, 2, 6'h01, 16'h0F0F);
        set_wb1(1, 2, 6'h02, 16'hF0F0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("rr%0d.wb_ready_0", c), wb_ready_0, (c % 2) == 0);
            check($sformatf("rr%0d.wb_ready_1", c), wb_ready_1, (c % 2) == 1);
            check($sformatf("rr%0d.wb_sel", c),     wb_sel,     (c % 2) == 1);
            $display("round robin cycle %0d: wb_sel=%0b", c, wb_sel);
            @(negedge clk);
        end

        // ---------------- hazard: retry or bypass ----------------
        idle_inputs();
        do_reset();
        set_wb0(1, 3, 6'h05, 16'hFFFF);
        set_read(1, 3, 6'h05, 6'h06, 16'hFFFF, 16'hFFFF);
        #1;
        check("haz0.wb_ready_0", wb_ready_0, 1);
        check("haz0.rd_ready",   rd_ready,   BYP);
        check("haz0.bypass_0",   bypass_0,   BYP);
        check("haz0.bypass_1",   bypass_1,   0);
        $display("hazard cycle 0: wb_ready_0=%0b rd_ready=%0b bypass=%0b%0b", wb_ready_0, rd_ready, bypass_1, bypass_0);
        if (!BYP) begin
            @(negedge clk);
            set_wb0(0, 0, 0, 0);
            #1;
            check("haz1.rd_ready", rd_ready, 1);
            check("haz1.raddr_0",  raddr_0,  6'h05);
            check("haz1.raddr_1",  raddr_1,  6'h06);
            check("haz1.write_en", write_en, 0);
            $display("hazard retry cycle: rd_ready=%0b", rd_ready);
        end
        @(negedge clk);

        // ---------------- starvation ----------------
        idle_inputs();
        do_reset();
        set_wb0(1, 1, 6'h0A, 16'hFFFF);
        set_read(1, 7, 6'h01, 6'h02, 16'h00FF, 16'hFF00);
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("starve%0d.rd_ready", c),   rd_ready,      c == 5);
            check($sformatf("starve%0d.wb_ready_0", c), wb_ready_0,    c != 5);
            check($sformatf("starve%0d.warp_sel", c),   warp_selector, (c == 5) ? 7 : 1);
            $display("starve cycle %0d: rd_ready=%0b ws=%0d", c, rd_ready, warp_selector);
            @(negedge clk);
        end

        // ---------------- idle hold and mid-stall reset ----------------
        idle_inputs();
        do_reset();
        set_read(1, 9, 6'h03, 6'h04, 16'h0001, 16'h0002);
        #1;
        check("hold.grant", rd_ready, 1);
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("hold%0d.warp_sel", c), warp_selector, 9);
            check($sformatf("hold%0d.rd_ready", c), rd_ready, 0);
            $display("idle cycle %0d: ws=%0d", c, warp_selector);
            @(negedge clk);
        end
        set_wb0(1, 1, 6'h0A, 16'hFFFF);
        set_read(1, 7, 6'h01, 6'h02, 16'h00FF, 16'hFF00);
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("stall%0d.rd_ready", c), rd_ready, 0);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.warp_sel",   warp_selector, 0);
        check("midrst.wb_ready_0", wb_ready_0,    0);
        check("midrst.rd_ready",   rd_ready,      0);
        $display("reset asserted mid-stall: ws=%0d", warp_selector);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("restart%0d.rd_ready", c), rd_ready, c == 5);
            $display("restart cycle %0d: rd_ready=%0b", c, rd_ready);
            @(negedge clk);
        end

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
